// File: rtl/hamming_secded_dec_pipe.sv
// rtl/hamming_secded_dec_pipe.sv - 2-stage Hamming SEC flit decoder with saturating error counters
// Define HAMMING_SECDED_EN to add an overall-parity MSB and double-error detection (SECDED).
module hamming_secded_dec_pipe #(
  parameter int PAR_W = 3,
  parameter int HDR_W = 4,
  parameter int CNT_W = 16,
  localparam int N = (1 << PAR_W) - 1,
`ifdef HAMMING_SECDED_EN
  localparam int OVP_W = 1,
`else
  localparam int OVP_W = 0,
`endif
  localparam int FLIT_W = N + HDR_W + OVP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  function automatic logic [PAR_W-1:0] calc_syn(input logic [N-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < PAR_W; j++) begin
        if ((((i + 1) >> j) & 1) != 0) s[j] = s[j] ^ cw[i];
      end
    end
    return s;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [FLIT_W-1:0] s1_flit_q, s1_flit_d;
  logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
  logic              s2_valid_q, s2_valid_d;
  logic [FLIT_W-1:0] s2_flit_q, s2_flit_d;
  logic [PAR_W-1:0]  s2_syn_q, s2_syn_d;
  logic              s2_corr_q, s2_corr_d;
  logic              s2_uncorr_q, s2_uncorr_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  logic              s2_adv, s1_adv, in_hs, out_hs;
  logic [N-1:0]      cw, flip_cw, fix_cw;
  logic              corr, uncorr;
  logic [FLIT_W-1:0] fixed_flit;
`ifdef HAMMING_SECDED_EN
  logic              par, fix_ovp;
`endif

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s2_adv;
    in_hs    = in_valid && in_ready;
    out_hs   = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_flit_d  = s1_flit_q;
    s1_syn_d   = s1_syn_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_flit_d  = in_flit;
      s1_syn_d   = calc_syn(in_flit[HDR_W +: N]);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // N = 2^PAR_W - 1, so every nonzero syndrome names a real codeword bit.
    cw      = s1_flit_q[HDR_W +: N];
    flip_cw = cw;
    for (int i = 0; i < N; i++) begin
      if (s1_syn_q == PAR_W'(i + 1)) flip_cw[i] = ~cw[i];
    end

`ifdef HAMMING_SECDED_EN
    par     = ^s1_flit_q[FLIT_W-1:HDR_W];
    fix_ovp = s1_flit_q[FLIT_W-1];
    fix_cw  = cw;
    corr    = par;
    uncorr  = !par && (s1_syn_q != '0);
    if (par) begin
      if (s1_syn_q == '0) fix_ovp = ~fix_ovp;
      else                fix_cw  = flip_cw;
    end
    fixed_flit = {fix_ovp, fix_cw, s1_flit_q[HDR_W-1:0]};
`else
    fix_cw     = flip_cw;
    corr       = (s1_syn_q != '0);
    uncorr     = 1'b0;
    fixed_flit = {fix_cw, s1_flit_q[HDR_W-1:0]};
`endif

    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    s2_flit_d   = s2_flit_q;
    s2_syn_d    = s2_syn_q;
    s2_corr_d   = s2_corr_q;
    s2_uncorr_d = s2_uncorr_q;
    if (s1_adv) begin
      s2_flit_d   = fixed_flit;
      s2_syn_d    = s1_syn_q;
      s2_corr_d   = corr;
      s2_uncorr_d = uncorr;
    end

    corr_cnt_d = corr_cnt_q;
    if (cnt_clr) corr_cnt_d = '0;
    else if (out_hs && s2_corr_q && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + CNT_W'(1);

    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) uncorr_cnt_d = '0;
    else if (out_hs && s2_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_flit_q    <= '0;
      s1_syn_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_flit_q    <= '0;
      s2_syn_q     <= '0;
      s2_corr_q    <= 1'b0;
      s2_uncorr_q  <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_flit_q    <= s1_flit_d;
      s1_syn_q     <= s1_syn_d;
      s2_valid_q   <= s2_valid_d;
      s2_flit_q    <= s2_flit_d;
      s2_syn_q     <= s2_syn_d;
      s2_corr_q    <= s2_corr_d;
      s2_uncorr_q  <= s2_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_flit     = s2_flit_q;
  assign out_syndrome = s2_syn_q;
  assign out_corr     = s2_corr_q;
  assign out_uncorr   = s2_uncorr_q;
  assign corr_cnt     = corr_cnt_q;
  assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// tb/tb_hamming_secded_dec_pipe.sv - scoreboard bench for hamming_secded_dec_pipe (default and CNT_W=2 instances)
// Build with HAMMING_SECDED_EN defined to exercise the SECDED variant.
module tb_hamming_secded_dec_pipe;
  localparam int N = 7;
  localparam int HW = 4;
`ifdef HAMMING_SECDED_EN
  localparam int FW = N + HW + 1;
`else
  localparam int FW = N + HW;
`endif

  typedef struct {
    logic [FW-1:0] flit;
    logic [2:0]    syn;
    logic          corr;
    logic          uncorr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_flit = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [FW-1:0] out_flit;
  logic [2:0]    out_syndrome;
  logic          out_corr, out_uncorr;
  logic          cnt_clr = 1'b0;
  logic [15:0]   corr_cnt, uncorr_cnt;

  logic          c_in_valid = 1'b0;
  logic          c_in_ready;
  logic [FW-1:0] c_in_flit = '0;
  logic          c_out_valid;
  logic          c_out_ready = 1'b1;
  logic [FW-1:0] c_out_flit;
  logic [2:0]    c_out_syndrome;
  logic          c_out_corr, c_out_uncorr;
  logic          c_cnt_clr = 1'b0;
  logic [1:0]    c_corr_cnt, c_uncorr_cnt;

  int   total = 0;
  int   bad = 0;
  int   exp_corr = 0;
  int   exp_uncorr = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  hamming_secded_dec_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_syndrome(out_syndrome), .out_corr(out_corr), .out_uncorr(out_uncorr),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_secded_dec_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_flit(c_in_flit),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_flit(c_out_flit),
    .out_syndrome(c_out_syndrome), .out_corr(c_out_corr), .out_uncorr(c_out_uncorr),
    .cnt_clr(c_cnt_clr), .corr_cnt(c_corr_cnt), .uncorr_cnt(c_uncorr_cnt)
  );

  // Build a flit from a clean codeword, an error mask and a header; ovp always matches the clean word.
  function automatic logic [FW-1:0] mk(input logic [6:0] clean, input logic [6:0] flip, input logic [3:0] h);
`ifdef HAMMING_SECDED_EN
    return {^clean, clean ^ flip, h};
`else
    return {clean ^ flip, h};
`endif
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  function automatic exp_t mk_exp(input logic [FW-1:0] f, input logic [2:0] s, input logic c, input logic u);
    exp_t e;
    e.flit = f; e.syn = s; e.corr = c; e.uncorr = u;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_extra: got out_flit=%h, required no output", out_flit);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if (out_flit !== mon_e.flit) begin
          bad++; $display("FAIL sb_flit: got %h, required %h", out_flit, mon_e.flit);
        end
        total++;
        if (out_syndrome !== mon_e.syn) begin
          bad++; $display("FAIL sb_syndrome: got %0d, required %0d", out_syndrome, mon_e.syn);
        end
        total++;
        if ({out_corr, out_uncorr} !== {mon_e.corr, mon_e.uncorr}) begin
          bad++; $display("FAIL sb_flags: got corr=%b uncorr=%b, required corr=%b uncorr=%b",
                          out_corr, out_uncorr, mon_e.corr, mon_e.uncorr);
        end
        if (mon_e.corr) exp_corr++;
        if (mon_e.uncorr) exp_uncorr++;
      end
    end
  end

  task automatic send(input logic [FW-1:0] f, input exp_t e);
    bit done;
    done = 0;
    in_flit = f;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d flits outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_flit, out_syndrome, out_corr, out_uncorr, corr_cnt, uncorr_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b flit=%h syn=%0d corr=%b uncorr=%b cc=%0d uc=%0d, required all 0",
               out_valid, out_flit, out_syndrome, out_corr, out_uncorr, corr_cnt, uncorr_cnt);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    exp_corr = 0;
    exp_uncorr = 0;
  endtask

  task automatic test_clean_latency();
    out_ready = 1'b1;
    send(mk(7'h66, 7'h00, 4'hA), mk_exp(mk(7'h66, 7'h00, 4'hA), 3'd0, 1'b0, 1'b0));
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early: out_valid=%b one cycle after handshake, required 0", out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL latency_two: out_valid=%b two cycles after handshake, required 1", out_valid);
    end
    wait_drain();
    total++;
    if (corr_cnt !== 16'd0) begin
      bad++; $display("FAIL clean_corr_cnt: got %0d, required 0", corr_cnt);
    end
  endtask

  task automatic test_single_error();
    send(mk(7'h66, 7'h10, 4'hA), mk_exp(mk(7'h66, 7'h00, 4'hA), 3'd5, 1'b1, 1'b0));
    wait_drain();
    total++;
    if (corr_cnt !== 16'd1) begin
      bad++; $display("FAIL single_corr_cnt: got %0d, required 1", corr_cnt);
    end
  endtask

  task automatic test_all_bits();
    logic [3:0] hdrs [2];
    hdrs[0] = 4'hA;
    hdrs[1] = 4'h5;
    for (int h = 0; h < 2; h++) begin
      for (int b = 0; b < N; b++) begin
        send(mk(7'h66, 7'(1 << b), hdrs[h]), mk_exp(mk(7'h66, 7'h00, hdrs[h]), 3'(b + 1), 1'b1, 1'b0));
      end
    end
    wait_drain();
    total++;
    if (corr_cnt !== 16'd15) begin
      bad++; $display("FAIL all_bits_corr_cnt: got %0d, required 15", corr_cnt);
    end
    total++;
    if (uncorr_cnt !== 16'(exp_uncorr)) begin
      bad++; $display("FAIL all_bits_uncorr_cnt: got %0d, required %0d", uncorr_cnt, exp_uncorr);
    end
  endtask

  task automatic test_back_to_back();
    bit            saw_low;
    bit            prev_stall;
    logic [FW-1:0] prev_flit;
    saw_low = 0;
    prev_stall = 0;
    prev_flit = '0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [6:0] c;
          c = enc(4'(i * 3 + 1));
          send(mk(c, 7'h00, 4'(i)), mk_exp(mk(c, 7'h00, 4'(i)), 3'd0, 1'b0, 1'b0));
        end
      end
      begin
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1;
          if (out_valid && !out_ready) begin
            if (prev_stall) begin
              total++;
              if (out_flit !== prev_flit) begin
                bad++; $display("FAIL stall_stable: out_flit %h changed to %h during stall", prev_flit, out_flit);
              end
            end
            prev_stall = 1;
            prev_flit = out_flit;
          end else begin
            prev_stall = 0;
          end
        end
      end
    join
    total++;
    if (saw_low !== 1'b1) begin
      bad++; $display("FAIL stall_in_ready: in_ready never dropped, required a drop while both stages full");
    end
    wait_drain();
  endtask

  task automatic test_random();
    bit stim_done;
    stim_done = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [6:0] c;
          logic [3:0] h;
          int         pos;
          c = enc(4'($urandom_range(0, 15)));
          h = 4'($urandom_range(0, 15));
          pos = $urandom_range(0, 7);
          send(mk(c, (pos == 0) ? 7'h00 : 7'(1 << (pos - 1)), h),
               mk_exp(mk(c, 7'h00, h), 3'(pos), pos != 0, 1'b0));
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    total++;
    if (corr_cnt !== 16'(exp_corr)) begin
      bad++; $display("FAIL random_corr_cnt: got %0d, required %0d", corr_cnt, exp_corr);
    end
  endtask

`ifdef HAMMING_SECDED_EN
  task automatic test_secded();
    logic [FW-1:0] dbl;
    logic [FW-1:0] ovp_bit;
    int            uc0;
    int            cc0;
    uc0 = exp_uncorr;
    cc0 = exp_corr;
    ovp_bit = '0;
    ovp_bit[FW-1] = 1'b1;
    out_ready = 1'b1;
    send({1'b0, 7'h66, 4'hA}, mk_exp({1'b0, 7'h66, 4'hA}, 3'd0, 1'b0, 1'b0));
    dbl = mk(7'h66, 7'h30, 4'hA);
    send(dbl, mk_exp(dbl, 3'd3, 1'b0, 1'b1));
    send(mk(7'h66, 7'h00, 4'hA) ^ ovp_bit, mk_exp(mk(7'h66, 7'h00, 4'hA), 3'd0, 1'b1, 1'b0));
    wait_drain();
    total++;
    if (uncorr_cnt !== 16'(uc0 + 1)) begin
      bad++; $display("FAIL secded_uncorr_cnt: got %0d, required %0d", uncorr_cnt, uc0 + 1);
    end
    total++;
    if (corr_cnt !== 16'(cc0 + 1)) begin
      bad++; $display("FAIL secded_corr_cnt: got %0d, required %0d", corr_cnt, cc0 + 1);
    end
  endtask
`endif

  task automatic test_saturate();
    bit seen;
    seen = 0;
    c_out_ready = 1'b1;
    c_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_in_flit = mk(7'h66, 7'(1 << i), 4'hA);
      @(posedge clk); #1;
    end
    c_in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    total++;
    if (c_corr_cnt !== 2'd3) begin
      bad++; $display("FAIL sat_corr_cnt: got %0d, required 3", c_corr_cnt);
    end
    c_in_flit = mk(7'h66, 7'h01, 4'hA);
    c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (c_out_valid) begin
        c_cnt_clr = 1'b1;
        seen = 1;
        break;
      end
    end
    @(posedge clk); #1;
    c_cnt_clr = 1'b0;
    total++;
    if (!seen || c_corr_cnt !== 2'd0) begin
      bad++; $display("FAIL sat_clear: got %0d (out_valid seen=%0d), required 0 and seen=1", c_corr_cnt, seen);
    end
    @(posedge clk); #1;
    total++;
    if (c_corr_cnt !== 2'd0) begin
      bad++; $display("FAIL sat_clear_hold: got %0d, required 0", c_corr_cnt);
    end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    in_flit = mk(7'h66, 7'h00, 4'hA);
    in_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL midreset_fill: out_valid=%b, required 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_flit !== '0) begin
      bad++; $display("FAIL midreset_async: out_valid=%b out_flit=%h, required 0 and 0", out_valid, out_flit);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    exp_corr = 0;
    exp_uncorr = 0;
    repeat (3) @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || corr_cnt !== 16'd0) begin
      bad++; $display("FAIL midreset_flush: out_valid=%b corr_cnt=%0d, required 0 and 0", out_valid, corr_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_latency();
    test_single_error();
    test_all_bits();
    test_back_to_back();
    test_random();
`ifdef HAMMING_SECDED_EN
    test_secded();
`endif
    test_saturate();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hamming_secded_dec_pipe.md
Name: hamming_secded_dec_pipe

Overview:
- Clocked, parametrised successor to the NoC flit error-decode unit.
- Accepts flits of {codeword, header} over a valid/ready handshake, computes the Hamming syndrome, corrects any single-bit error in place and forwards the flit through a 2-stage pipeline.
- Exposes per-flit error flags and saturating error counters for link-health monitoring.
- Sits between a router input port and the local PE interface.

Parameters:
- PAR_W, 3: Hamming parity bits; codeword width N = 2^PAR_W - 1 (default 7).
- HDR_W, 4: header bits in flit LSBs; passed through untouched.
- CNT_W, 16: width of error counters.
- FLIT_W, derived: N + HDR_W, plus 1 with SECDED_EN. Not user-overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  block can accept input.
- in_flit  in  FLIT_W  {[ovp,] codeword[N-1:0], header[HDR_W-1:0]}.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts.
- out_flit  out  FLIT_W  corrected flit, same layout.
- out_syndrome  out  PAR_W  syndrome of the flit on out_flit.
- out_corr  out  1  single error corrected in this flit.
- out_uncorr  out  1  uncorrectable error; 0 without SECDED_EN.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  corrected-flit count.
- uncorr_cnt  out  CNT_W  uncorrectable-flit count; 0 without SECDED_EN.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - out_valid=0, out_flit=0, out_syndrome=0, out_corr=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0.
  - Both stage valids cleared; in_ready=1 after reset.
  - Reset mid-operation discards in-flight flits.
- Bit numbering: codeword[i] is Hamming position i+1.
- Syndrome: bit j of syndrome s = XOR of codeword[i] over all i with bit j of (i+1) set.
- Stage 1 (S1), on input handshake: registers in_flit and s.
- Stage 2 (S2): if s != 0, flip codeword[s-1].
  - No range check is needed because N = 2^PAR_W - 1.
  - Header is never modified. Registers the result and flags.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational from out_ready).
- Latency: 2 cycles from input handshake to out_valid when unstalled; throughput 1 flit/cycle.
- Stall: out_flit and all flags hold stable while out_valid=1 && out_ready=0. No flit is dropped or duplicated.
- Simultaneous S1 load and S1 drain in the same cycle is legal and keeps full throughput.
- Counters:
  - Increment on output handshake (out_valid && out_ready) when the matching flag is set.
  - Saturate at 2^CNT_W - 1; no wrap.
  - cnt_clr takes priority over a same-cycle increment; that event is not counted.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Defined:
  - Flit MSB is an overall parity bit ovp = XOR of all codeword bits.
  - Let p = XOR(ovp, codeword).
  - s=0, p=0: clean.
  - p=1: single error, corrected. If s=0 flip ovp, else flip codeword[s-1]. Set out_corr.
  - s!=0, p=0: double error. No modification; set out_uncorr, clear out_corr; uncorr_cnt counts.
- Undefined:
  - No ovp bit; FLIT_W = N + HDR_W.
  - out_uncorr and uncorr_cnt are tied to 0.
  - Any nonzero syndrome is corrected (SEC only).

Test Plan:
- Defaults, no macro. Reset, then in_flit=11'h66A with out_ready=1 -> out_flit=11'h66A 2 cycles later; syndrome=0, corr=0, corr_cnt=0.
- in_flit=11'h76A (position 5 flipped) -> out_flit=11'h66A, out_syndrome=3'd5, out_corr=1; corr_cnt=1 after handshake.
- Stream 8 back-to-back flits with out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full; all 8 flits arrive in order, none lost; out_flit is stable during the stall.
- Flip each of codeword bits 0..6 in turn on 11'h66A -> output is always 11'h66A with syndromes 1..7. Repeat with header 4'h5 -> header unchanged.
- CNT_W=2: send 5 erroneous flits -> corr_cnt saturates at 3. Assert cnt_clr in the same cycle as a 6th erroneous handshake -> corr_cnt=0.
- HAMMING_SECDED_EN: in_flit={1'b0,7'h66,4'hA} -> clean. Flip bits 4 and 5 -> out_uncorr=1, flit unmodified, uncorr_cnt=1. Flip only ovp -> corrected, syndrome 0, out_corr=1. Assert rst_n=0 mid-stream -> out_valid=0 immediately.
